inner_product_acc: RTL
======================

// Module: inner_product_acc
// PURPOSE
//  Sequential signed fixed-point inner-product engine: streams LEN element pairs (a,b),
//  multiply-accumulates them, rescales and emits one W-bit result with a 1-cycle pulse.
//  Sits directly upstream of the pseudoinverse result registers: result -> register data,
//  result_valid -> register enable. One engine is instanced per matrix row/column product.
// PARAMETERS
//  W     16  element and result width, signed two's complement
//  FRAC   8  fractional bits of a_in, b_in and result (Q(W-FRAC).FRAC)
//  LEN    8  elements per inner product, >=2
// PORTS
//  clk           in   1        rising-edge clock
//  reset         in   1        asynchronous, active-high reset
//  clear         in   1        synchronous abort: return to IDLE, discard partial sum
//  start         in   1        begin a new product; honoured only in IDLE
//  a_in          in   W        element of vector a
//  b_in          in   W        element of vector b
//  in_valid      in   1        a_in/b_in valid this cycle
//  in_ready      out  1        engine accepts an element this cycle
//  result        out  W        rescaled inner product
//  result_valid  out  1        1-cycle pulse, result updated this cycle
//  busy          out  1        high whenever state != IDLE
//  overflow      out  1        result did not fit in W bits (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE, acc=0, count=0; result, result_valid, in_ready, busy, overflow = 0.
//  - FSM IDLE -> ACCUM on start; ACCUM -> DONE on acceptance of element LEN-1;
//    DONE -> IDLE unconditionally after one cycle.
//  - IDLE: in_ready=0. start: acc<=0, count<=0. in_valid is ignored.
//  - ACCUM: in_ready=1. Beat = in_valid & in_ready: acc <= acc + a_in*b_in, count++.
//    in_valid gaps stall without penalty. start is ignored while busy.
//  - DONE: result <= acc >>> FRAC, arithmetic shift (floor); result_valid=1 for exactly
//    this cycle; overflow updated in the same cycle. Latency: result_valid is high one
//    cycle after the last beat. Minimum start-to-result time is LEN+1 cycles.
//  - result and overflow hold their values until the next DONE cycle.
//  - Widths: product 2W bits; acc ACC_W = 2W + clog2(LEN) bits. Acc never wraps.
//  - clear has priority over start and beats: state<=IDLE, acc<=0, count<=0,
//    no result_valid. result and overflow keep their previous values.
//    If clear coincides with DONE, result_valid is suppressed and result is not updated.
//  - reset asserted mid-operation: immediate return to reset values, no pulse.
//  - start and clear in the same IDLE cycle: clear wins, stay IDLE.
// CONFIGURATION
//  INNER_PRODUCT_SATURATE_EN defined: if the shifted acc exceeds the W-bit signed range,
//    result is clamped to 2^(W-1)-1 or -2^(W-1), and overflow=1.
//  Not defined: result = low W bits of the shifted acc (wrap). overflow still reports
//    out-of-range, result not clamped.
// STRUCTURE
//  Shared package pinv_pkg: FSM state encoding (IDLE, ACCUM, DONE), the ACC_W width
//  function, and the default W, FRAC and LEN constants used by the other pseudoinverse blocks.
//  Sub-module pinv_mac: combinational signed W x W multiply plus ACC_W add. FSM and
//  counter stay in inner_product_acc.
// TESTING (W=16, FRAC=8, LEN=4)
//  1. Reset with all inputs toggling -> all outputs 0, in_ready=0.
//  2. start; a=[256,512,768,1024], b=[256]x4 back-to-back -> result=2560, result_valid 1 cycle
//     one cycle after the 4th beat, overflow=0.
//  3. Same vectors with in_valid low 2 cycles between beats -> result=2560; start pulsed
//     mid-ACCUM is ignored.
//  4. a=b=32767 x4 -> wrap build: result=-1024 (0xFC00), overflow=1.
//     SATURATE_EN build: result=32767, overflow=1.
//  5. a=[-256,256,-256,256], b=[256]x4 -> result=0; a=[-1]x4, b=[1]x4 -> result=-1 (floor).
//  6. clear after 2 beats -> IDLE, no result_valid, previous result held; a fresh start
//     then gives a correct sum. Reset asserted mid-ACCUM gives the same abort behaviour.

Source files
------------

// File: rtl/pinv_pkg.sv
// Shared definitions for the pseudoinverse datapath blocks.
// Holds the FSM state encoding used by the inner-product engines, the default element
// width / fraction / vector length, and the accumulator width helper.
package pinv_pkg;

  localparam int W_DEF    = 16;
  localparam int FRAC_DEF = 8;
  localparam int LEN_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // A full product needs 2W bits. Summing LEN of them adds clog2(LEN) bits of
  // headroom, so the accumulator can never wrap.
  function automatic int acc_w(input int w, input int len);
    return 2 * w + $clog2(len);
  endfunction

endpackage

// File: rtl/inner_product_acc_if.sv
// Handshake/data bundle between an inner-product engine and its producer/consumer.
// Ports: clear, start, a_in, b_in, in_valid (toward engine);
//        in_ready, result, result_valid, busy, overflow (from engine).
// The engine connects to the slave modport; the producer side uses master.
interface inner_product_acc_if
  import pinv_pkg::*;
#(
  parameter int W = W_DEF
);

  logic                clear;
  logic                start;
  logic signed [W-1:0] a_in;
  logic signed [W-1:0] b_in;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] result;
  logic                result_valid;
  logic                busy;
  logic                overflow;

  modport slave (
    input  clear, start, a_in, b_in, in_valid,
    output in_ready, result, result_valid, busy, overflow
  );

  modport master (
    output clear, start, a_in, b_in, in_valid,
    input  in_ready, result, result_valid, busy, overflow
  );

endinterface

// File: rtl/pinv_mac.sv
// Combinational signed multiply-accumulate step: acc_o = acc_i + a_i * b_i.
// Latency: 0 (purely combinational). Backpressure: none, the caller decides when to register.
// Ports: a_i/b_i W-bit signed operands, acc_i/acc_o ACC_W-bit signed accumulator.
module pinv_mac #(
  parameter int W     = 16,
  parameter int ACC_W = 35
) (
  input  logic signed [W-1:0]     a_i,
  input  logic signed [W-1:0]     b_i,
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [2*W-1:0] prod;

  assign prod  = a_i * b_i;
  // Sign-extend the full-precision product up to the accumulator width.
  assign acc_o = acc_i + {{(ACC_W-2*W){prod[2*W-1]}}, prod};

endmodule

// File: rtl/inner_product_acc.sv
// Sequential signed fixed-point inner product: LEN (a,b) beats -> one rescaled W-bit result.
// Latency: result_valid pulses one cycle after the last accepted beat (>= LEN+1 from start).
// Backpressure: in_ready high only in ACCUM; in_valid gaps stall the count without penalty.
// Ports: clk, reset (async, active-high) plus the slave side of inner_product_acc_if.
// Build option: define INNER_PRODUCT_SATURATE_EN to clamp out-of-range results instead of
// wrapping; overflow reports out-of-range in both builds.
module inner_product_acc
  import pinv_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int FRAC = FRAC_DEF,
  parameter int LEN  = LEN_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  inner_product_acc_if.slave    bus
);

  localparam int ACC_W = acc_w(W, LEN);
  localparam int CNT_W = $clog2(LEN);

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic signed [W-1:0]     result_q, result_d;
  logic                    ovf_q, ovf_d;

  logic signed [ACC_W-1:0] mac_sum;
  logic signed [ACC_W-1:0] shifted;
  logic                    fits;
  logic signed [W-1:0]     res_fmt;
  logic                    done_fire;

  pinv_mac #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_mac (
    .a_i   (bus.a_in),
    .b_i   (bus.b_in),
    .acc_i (acc_q),
    .acc_o (mac_sum)
  );

  // Arithmetic shift gives floor rounding of the Q.2FRAC sum back to Q.FRAC.
  assign shifted = acc_q >>> FRAC;

  // Value fits in W signed bits iff every bit from W-1 upward equals the sign.
  assign fits = (&shifted[ACC_W-1:W-1]) | ~(|shifted[ACC_W-1:W-1]);

`ifdef INNER_PRODUCT_SATURATE_EN
  assign res_fmt = fits ? shifted[W-1:0]
                        : (shifted[ACC_W-1] ? {1'b1, {(W-1){1'b0}}}
                                            : {1'b0, {(W-1){1'b1}}});
`else
  assign res_fmt = shifted[W-1:0];
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    done_fire = 1'b0;

    if (bus.clear) begin
      // Abort wins over everything, including the DONE publish.
      state_d = ST_IDLE;
      acc_d   = '0;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            count_d = '0;
          end
        end
        ST_ACCUM: begin
          if (bus.in_valid) begin
            acc_d = mac_sum;
            if (count_q == CNT_W'(LEN - 1)) begin
              count_d = '0;
              state_d = ST_DONE;
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          state_d   = ST_IDLE;
          result_d  = res_fmt;
          ovf_d     = ~fits;
          done_fire = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  // During the DONE cycle the freshly formatted value is presented alongside the pulse so a
  // downstream register enabled by result_valid captures it; afterwards the held copy shows.
  assign bus.in_ready     = (state_q == ST_ACCUM);
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.result_valid = done_fire;
  assign bus.result       = done_fire ? res_fmt : result_q;
  assign bus.overflow     = done_fire ? ~fits   : ovf_q;

endmodule
